// File: rtl/write_path_pkg.sv
// write_path_pkg: shared state type and constants for the result write path
package write_path_pkg;
   typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} packer_state_t;
   localparam int BYTES_PER_WORD = 4;
   localparam logic [7:0] PAD_BYTE = 8'h00;
endpackage

// File: rtl/result_word_packer_if.sv
// result_word_packer_if: byte-stream input and word-write output of the packer
interface result_word_packer_if #(parameter int CAPACITY = 256);
   localparam int AW = $clog2(CAPACITY);
   logic start, in_valid, in_ready, in_last, write_en, done;
   logic [7:0] in_data;
   logic [AW-1:0] addr;
   logic [0:3][7:0] out_data;
   modport master (output start, in_valid, in_data, in_last, input in_ready, write_en, addr, out_data, done);
   modport slave (input start, in_valid, in_data, in_last, output in_ready, write_en, addr, out_data, done);
endinterface

// File: rtl/byte_lane_assembler.sv
// byte_lane_assembler: gathers stream bytes into four lanes and pads short words
// RESULT_PACKER_LITTLE_ENDIAN_EN: when defined, the first byte of a word lands in lane 3
module byte_lane_assembler
   import write_path_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic            clr_i,
   input  logic            accept_i,
   input  logic [7:0]      data_i,
   input  logic            last_i,
   output logic            full_o,
   output logic [0:3][7:0] lanes_o
);
`ifdef RESULT_PACKER_LITTLE_ENDIAN_EN
   localparam bit LE = 1'b1;
`else
   localparam bit LE = 1'b0;
`endif
   logic [1:0] lane_idx_q, lane_idx_d;
   logic [0:3][7:0] lanes_q, lanes_d;
   assign full_o = accept_i && (last_i || lane_idx_q == 2'(BYTES_PER_WORD - 1));
   assign lanes_o = lanes_q;
   // place the accepted byte, pad lanes after a final byte, rewind the index once the word is complete
   always_comb begin
      lanes_d = lanes_q;
      lane_idx_d = clr_i ? 2'd0 : lane_idx_q;
      if (accept_i) begin
         for (int k = 0; k < BYTES_PER_WORD; k++)
            if (2'(k) == lane_idx_q) lanes_d[LE ? 3 - k : k] = data_i;
            else if (last_i && 2'(k) > lane_idx_q) lanes_d[LE ? 3 - k : k] = PAD_BYTE;
         lane_idx_d = full_o ? 2'd0 : lane_idx_q + 2'd1;
      end
   end
   // lane and index registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         lanes_q <= '0;
         lane_idx_q <= '0;
      end else begin
         lanes_q <= lanes_d;
         lane_idx_q <= lane_idx_d;
      end
endmodule

// File: rtl/result_word_packer.sv
// result_word_packer: packs a byte stream into 32-bit memory writes and flags frame completion
// RESULT_PACKER_LITTLE_ENDIAN_EN: selects little-endian lane order in byte_lane_assembler
module result_word_packer
   import write_path_pkg::*;
#(
   parameter int CAPACITY   = 256,
   parameter int WORD_COUNT = 43
) (
   input logic                 clk,
   input logic                 rst_n,
   result_word_packer_if.slave bus
);
   localparam int AW = $clog2(CAPACITY);
   localparam int CW = $clog2(WORD_COUNT + 1);
   packer_state_t state_q, state_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic last_q, last_d, accept, full, clr;
   assign accept = bus.in_valid && state_q == COLLECT;
   assign clr = bus.start && (state_q == IDLE || state_q == DONE);
   assign bus.in_ready = state_q == COLLECT;
   assign bus.write_en = state_q == WRITE;
   assign bus.done = state_q == DONE;
   assign bus.addr = addr_q;
   byte_lane_assembler u_lanes (
      .clk      (clk),
      .rst_n    (rst_n),
      .clr_i    (clr),
      .accept_i (accept),
      .data_i   (bus.in_data),
      .last_i   (bus.in_last),
      .full_o   (full),
      .lanes_o  (bus.out_data)
   );
   // next state plus word counter, address and end-of-frame bookkeeping
   always_comb begin
      state_d = state_q;
      addr_d = addr_q;
      cnt_d = cnt_q;
      last_d = last_q;
      case (state_q)
         IDLE, DONE: if (clr) begin
            state_d = COLLECT;
            addr_d = '0;
            cnt_d = '0;
            last_d = 1'b0;
         end
         COLLECT: if (full) begin
            state_d = WRITE;
            last_d = bus.in_last;
         end
         WRITE: begin
            state_d = (last_q || cnt_q == CW'(WORD_COUNT - 1)) ? DONE : COLLECT;
            addr_d = addr_q + AW'(BYTES_PER_WORD);
            cnt_d = cnt_q + CW'(1);
         end
         default: state_d = IDLE;
      endcase
   end
   // state and bookkeeping registers
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         state_q <= IDLE;
         addr_q <= '0;
         cnt_q <= '0;
         last_q <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q <= addr_d;
         cnt_q <= cnt_d;
         last_q <= last_d;
      end
endmodule

// File: tb/tb_result_word_packer.sv
// tb_result_word_packer: directed checks of the result word packer
module tb_result_word_packer;
   logic clk = 1'b0, rst_n = 1'b0;
   int n_cmp = 0, n_err = 0;
   logic [7:0] wa_q[$];
   logic [31:0] wd_q[$];
   result_word_packer_if #(.CAPACITY(256)) bus ();
   result_word_packer #(.CAPACITY(256), .WORD_COUNT(43)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, want %h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] pack(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2, input logic [7:0] b3);
`ifdef RESULT_PACKER_LITTLE_ENDIAN_EN
      return {b3, b2, b1, b0};
`else
      return {b0, b1, b2, b3};
`endif
   endfunction
   always @(negedge clk)
      if (rst_n && bus.write_en) begin
         wa_q.push_back(bus.addr);
         wd_q.push_back(bus.out_data);
         chk("ready_in_write", 32'(bus.in_ready), 0);
      end
   task automatic idle();
      bus.in_valid = 1'b0;
      bus.in_last = 1'b0;
   endtask
   task automatic send(input logic [7:0] d, input logic l = 1'b0);
      int t = 0;
      bus.in_valid = 1'b1;
      bus.in_data = d;
      bus.in_last = l;
      while (!bus.in_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus.in_ready) chk("send_timeout", 32'(bus.in_ready), 1);
      @(negedge clk);
   endtask
   task automatic go();
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
   endtask
   task automatic rst();
      rst_n = 1'b0;
      idle();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      wa_q.delete();
      wd_q.delete();
   endtask
   initial begin
      bus.start = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 8'h55;
      bus.in_last = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_we", 32'(bus.write_en), 0);
      chk("rst_addr", 32'(bus.addr), 0);
      chk("rst_data", bus.out_data, 0);
      chk("rst_done", 32'(bus.done), 0);
      chk("rst_ready", 32'(bus.in_ready), 0);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("idle_ready", 32'(bus.in_ready), 0);
      chk("idle_writes", wa_q.size(), 0);
      idle();
      go();
      send(8'h11); send(8'h22); send(8'h33); send(8'h44);
      chk("w1_we", 32'(bus.write_en), 1);
      chk("w1_addr", 32'(bus.addr), 0);
      chk("w1_data", bus.out_data, pack(8'h11, 8'h22, 8'h33, 8'h44));
      chk("w1_ready", 32'(bus.in_ready), 0);
      idle();
      @(negedge clk);
      chk("w1_we_once", 32'(bus.write_en), 0);
      chk("w1_nwr", wa_q.size(), 1);
      rst();
      go();
      for (int i = 0; i < 172; i++) send(8'(i));
      chk("full_last_we", 32'(bus.write_en), 1);
      chk("full_last_done", 32'(bus.done), 0);
      bus.in_data = 8'hEE;
      @(negedge clk);
      chk("full_done", 32'(bus.done), 1);
      chk("full_we_off", 32'(bus.write_en), 0);
      chk("done_ready", 32'(bus.in_ready), 0);
      repeat (3) @(negedge clk);
      chk("done_held", 32'(bus.done), 1);
      chk("full_nwr", wa_q.size(), 43);
      for (int k = 0; k < 43 && k < wa_q.size(); k++) begin
         chk("full_addr", 32'(wa_q[k]), 32'(4 * k));
         chk("full_data", wd_q[k], pack(8'(4 * k), 8'(4 * k + 1), 8'(4 * k + 2), 8'(4 * k + 3)));
      end
      idle();
      wa_q.delete();
      wd_q.delete();
      go();
      chk("restart_done", 32'(bus.done), 0);
      send(8'hAA); send(8'hBB, 1'b1);
      chk("short_we", 32'(bus.write_en), 1);
      chk("short_addr", 32'(bus.addr), 0);
      chk("short_data", bus.out_data, pack(8'hAA, 8'hBB, 8'h00, 8'h00));
      idle();
      @(negedge clk);
      chk("short_done", 32'(bus.done), 1);
      chk("short_nwr", wa_q.size(), 1);
      rst();
      go();
      for (int i = 0; i < 16; i++) begin
         idle();
         repeat ($urandom_range(0, 3)) @(negedge clk);
         send(8'(8'h30 + i));
      end
      idle();
      repeat (3) @(negedge clk);
      chk("gap_nwr", wa_q.size(), 4);
      for (int k = 0; k < 4 && k < wa_q.size(); k++) begin
         chk("gap_addr", 32'(wa_q[k]), 32'(4 * k));
         chk("gap_data", wd_q[k], pack(8'(8'h30 + 4 * k), 8'(8'h31 + 4 * k), 8'(8'h32 + 4 * k), 8'(8'h33 + 4 * k)));
      end
      chk("gap_done", 32'(bus.done), 0);
      rst();
      go();
      for (int i = 0; i < 22; i++) send(8'(i));
      chk("mid_nwr", wa_q.size(), 5);
      #2 rst_n = 1'b0;
      idle();
      #1;
      chk("mid_rst_we", 32'(bus.write_en), 0);
      chk("mid_rst_ready", 32'(bus.in_ready), 0);
      chk("mid_rst_addr", 32'(bus.addr), 0);
      wa_q.delete();
      wd_q.delete();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("mid_no_write", wa_q.size(), 0);
      chk("mid_done", 32'(bus.done), 0);
      go();
      send(8'hC1); send(8'hC2); send(8'hC3); send(8'hC4);
      idle();
      @(negedge clk);
      chk("after_nwr", wa_q.size(), 1);
      if (wa_q.size() > 0) begin
         chk("after_addr", 32'(wa_q[0]), 0);
         chk("after_data", wd_q[0], pack(8'hC1, 8'hC2, 8'hC3, 8'hC4));
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
